bram_rr_arbiter: RTL
====================

BRAM_RR_ARBITER -- requirements
Module: bram_rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 128, SHALL set memory data width.
REQ-002 Parameter DEPTH, default 1024, SHALL set memory depth, which SHALL be 2**AW.
REQ-003 Parameter AW, default 10, SHALL set address width.
REQ-004 Parameter MAX_BURST, default 16, SHALL set max beats per grant (range 1..256).
REQ-005 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 r<i>_valid  in  1  requester i (i = 0,1) beat valid.
REQ-008 r<i>_ready  out  1  beat accepted when valid and ready.
REQ-009 r<i>_we  in  1  beat is a write (1) or a read (0).
REQ-010 r<i>_last  in  1  final beat of requester burst.
REQ-011 r<i>_addr  in  AW  beat address.
REQ-012 r<i>_wdata  in  WIDTH  write data.
REQ-013 r<i>_rvalid  out  1  read data valid.
REQ-014 r<i>_rdata  out  WIDTH  read data.
REQ-015 mem_en, mem_we  out  1 each  memory enable and write enable, to a single-port BRAM port.
REQ-016 mem_addr  out  AW; mem_din  out  WIDTH; mem_dout  in  WIDTH; memory read latency SHALL be exactly 1 cycle.

Function
REQ-017 FSM states SHALL be IDLE, OWN0 and OWN1; r<i>_ready SHALL be 1 only in OWNi, combinationally.
REQ-018 In IDLE with one valid, the FSM SHALL go to that port's OWN state; with both valid, it SHALL go to the port that is not last_owner; with none valid, it SHALL stay in IDLE.
REQ-019 last_owner SHALL update on every transition out of IDLE.
REQ-020 In OWNi, the FSM SHALL go to IDLE when an accepted beat has r<i>_last=1, or when beat_cnt reaches MAX_BURST-1 on an accepted beat, or when r<i>_valid=0.
REQ-021 beat_cnt SHALL clear on entry to OWNi and increment per accepted beat.
REQ-022 Every release SHALL be followed by exactly one IDLE cycle; sustained throughput SHALL be MAX_BURST beats per MAX_BURST+1 cycles.
REQ-023 On an accepted beat, the block SHALL drive mem_en=1 and pass the owner's we, addr and wdata to mem_we, mem_addr and mem_din in the same cycle; otherwise mem_en, mem_we, mem_addr and mem_din SHALL be 0.
REQ-024 An accepted read SHALL assert the owner's r<i>_rvalid for exactly one cycle, one cycle later, with r<i>_rdata=mem_dout; write beats SHALL produce no rvalid.
REQ-025 The rvalid pipeline SHALL be tracked per port, so a final read's rvalid is delivered even when the FSM is already in IDLE or OWN of the other port.
REQ-026 r<i>_rdata SHALL be 0 whenever r<i>_rvalid=0; the non-owner port SHALL never see rvalid.
REQ-027 The block SHALL perform no address range check or translation.
REQ-028 A read following a write to the same address SHALL return the written data, relying on sequential BRAM access order.

Reset
REQ-029 With rst=1 at a clock edge, the block SHALL set state IDLE, last_owner 1, beat_cnt 0 and both rvalid registers 0.
REQ-030 While rst=1, r<i>_ready, mem_en and mem_we SHALL be 0.
REQ-031 A reset asserted mid-burst SHALL abandon the burst, and no rvalid SHALL follow the reset cycle.
REQ-032 After reset, port 0 SHALL win the first contended arbitration.

Verification
REQ-033 rst high for 2 cycles with both valid -> ready, mem_en and rvalid all 0; 1 cycle after rst falls, r0_ready=1.
REQ-034 Both valid continuously, last=0, MAX_BURST=16 -> 16 port-0 beats, 1 IDLE cycle, 16 port-1 beats, repeating.
REQ-035 Port 0 writes 0xA5 to addr 5, then reads addr 5 -> r0_rvalid=1 one cycle after read accept with r0_rdata=0xA5; r1_rvalid stays 0.
REQ-036 Port 1 sends a 3-beat read burst, last on beat 3, while port 0 waits -> 3 rvalid pulses on port 1, 1 IDLE cycle, then r0_ready=1.
REQ-037 Port 0 owner drops valid after 2 beats, port 1 valid -> next cycle IDLE, then OWN1.
REQ-038 rst pulsed on beat 4 of a port-1 read burst -> no r1_rvalid after it; next contended grant goes to port 0.

Source files
------------

// File: rtl/bram_rr_arbiter_if.sv
// Requester-side beat channel of the BRAM round-robin arbiter: request,
// handshake and read-return signals for one port.
interface bram_rr_arbiter_if #(
  parameter int WIDTH = 128,
  parameter int AW    = 10
);
  logic             valid;
  logic             ready;
  logic             we;
  logic             last;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] wdata;
  logic             rvalid;
  logic [WIDTH-1:0] rdata;

  modport master (
    output valid, we, last, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, last, addr, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/bram_rr_arbiter.sv
// Two-requester round-robin arbiter onto one single-port BRAM port with
// bounded bursts, a one-cycle gap between grants and per-port read return.
module bram_rr_arbiter #(
  parameter int WIDTH     = 128,
  parameter int DEPTH     = 1024,
  parameter int AW        = 10,
  parameter int MAX_BURST = 16
) (
  input  logic             clk,
  input  logic             rst,
  bram_rr_arbiter_if.slave r0,
  bram_rr_arbiter_if.slave r1,
  output logic             mem_en,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_din,
  input  logic [WIDTH-1:0] mem_dout
);

  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  if (DEPTH != (1 << AW)) begin : g_bad_depth
    $error("bram_rr_arbiter: DEPTH must equal 2**AW");
  end
  if (MAX_BURST < 1 || MAX_BURST > 256) begin : g_bad_burst
    $error("bram_rr_arbiter: MAX_BURST must be in 1..256");
  end

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state, state_nx;
  logic          last_owner, last_owner_nx;
  logic [CW-1:0] beat_cnt, beat_cnt_nx;
  logic          rv0, rv1;
  logic          rdy0, rdy1, acc0, acc1;
  logic          own_valid, own_last, burst_end;

  // Ready is gated by rst so nothing is accepted in a reset cycle,
  // even if the state register still holds an OWN state.
  always_comb begin
    rdy0 = (state == OWN0) && !rst;
    rdy1 = (state == OWN1) && !rst;
    acc0 = rdy0 && r0.valid;
    acc1 = rdy1 && r1.valid;
  end

  always_comb begin
    state_nx      = state;
    last_owner_nx = last_owner;
    beat_cnt_nx   = beat_cnt;
    own_valid     = (state == OWN1) ? r1.valid : r0.valid;
    own_last      = (state == OWN1) ? r1.last  : r0.last;
    burst_end     = (beat_cnt == CW'(MAX_BURST - 1));
    unique case (state)
      IDLE: begin
        beat_cnt_nx = '0;
        if (r0.valid && (!r1.valid || last_owner)) begin
          state_nx      = OWN0;
          last_owner_nx = 1'b0;
        end else if (r1.valid) begin
          state_nx      = OWN1;
          last_owner_nx = 1'b1;
        end
      end
      OWN0, OWN1: begin
        if (!own_valid) begin
          state_nx = IDLE;
        end else begin
          beat_cnt_nx = beat_cnt + CW'(1);
          if (own_last || burst_end) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nx;
      last_owner <= last_owner_nx;
      beat_cnt   <= beat_cnt_nx;
    end
  end

  always_comb begin
    mem_en   = acc0 || acc1;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (acc0) begin
      mem_we   = r0.we;
      mem_addr = r0.addr;
      mem_din  = r0.wdata;
    end else if (acc1) begin
      mem_we   = r1.we;
      mem_addr = r1.addr;
      mem_din  = r1.wdata;
    end
  end

  // Read returns are tracked per port so a final beat's data still lands
  // after the grant has moved on.
  always_ff @(posedge clk) begin
    if (rst) begin
      rv0 <= 1'b0;
      rv1 <= 1'b0;
    end else begin
      rv0 <= acc0 && !r0.we;
      rv1 <= acc1 && !r1.we;
    end
  end

  always_comb begin
    r0.ready  = rdy0;
    r1.ready  = rdy1;
    r0.rvalid = rv0;
    r1.rvalid = rv1;
    r0.rdata  = rv0 ? mem_dout : '0;
    r1.rdata  = rv1 ? mem_dout : '0;
  end

endmodule
